// File: rtl/floor_request_bank.sv
// floor_request_bank
//   Bank of set/clear request flip-flops, one per floor, for the elevator
//   controller. Call buttons set a floor's request, and a "floor served"
//   report clears it. The bank also publishes registered summaries of the
//   pending set.
//
// Parameters:
//   FLOORS     number of floors / request bits (2..32)
//   IDX_W      floor index width, 2^IDX_W >= FLOORS
//   CNT_W      width of req_count, must be able to hold FLOORS
//   EDGE_MODE  1 = capture on button rising edge, 0 = capture while high
//   PRESET_VAL request vector loaded on reset
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   enable       1 = accept new presses (clears always act)
//   btn          synchronised call buttons, bit i = floor i
//   clr_valid    clear the request at clr_idx this cycle
//   clr_idx      floor being served
//   req          latched pending requests
//   any_req      OR of req
//   req_count    popcount of req
//   lowest_idx   lowest pending floor (0 if none)
//   highest_idx  highest pending floor (0 if none)
//   new_req      pulse: some req bit rose 0->1 on this update
//   clr_err      pulse: clr_valid with clr_idx >= FLOORS
module floor_request_bank #(
  parameter int unsigned       FLOORS     = 8,
  parameter int unsigned       IDX_W      = 3,
  parameter int unsigned       CNT_W      = 4,
  parameter bit                EDGE_MODE  = 1'b1,
  parameter logic [FLOORS-1:0] PRESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [FLOORS-1:0] btn,
  input  logic              clr_valid,
  input  logic [IDX_W-1:0]  clr_idx,
  output logic [FLOORS-1:0] req,
  output logic              any_req,
  output logic [CNT_W-1:0]  req_count,
  output logic [IDX_W-1:0]  lowest_idx,
  output logic [IDX_W-1:0]  highest_idx,
  output logic              new_req,
  output logic              clr_err
);

  function automatic logic [CNT_W-1:0] f_count(input logic [FLOORS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < FLOORS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Scan from the top down so the last hit is the lowest set bit.
  function automatic logic [IDX_W-1:0] f_lowest(input logic [FLOORS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < FLOORS; i++)
      if (v[FLOORS-1-i]) idx = IDX_W'(FLOORS-1-i);
    return idx;
  endfunction

  // Scan from the bottom up so the last hit is the highest set bit.
  function automatic logic [IDX_W-1:0] f_highest(input logic [FLOORS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < FLOORS; i++)
      if (v[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  logic [FLOORS-1:0] r_req;
  logic [FLOORS-1:0] r_btn_q;
  logic              r_any;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_lowest;
  logic [IDX_W-1:0]  r_highest;
  logic              r_new;
  logic              r_clr_err;

  logic [FLOORS-1:0] w_cap;
  logic [FLOORS-1:0] w_set;
  logic [FLOORS-1:0] w_clr;
  logic              w_clr_ok;
  logic              w_clr_bad;
  logic [FLOORS-1:0] w_req_n;

  always_comb begin
    w_cap     = EDGE_MODE ? (btn & ~r_btn_q) : btn;
    w_set     = enable ? w_cap : '0;
    w_clr_ok  = clr_valid && (32'(clr_idx) < FLOORS);
    w_clr_bad = clr_valid && !w_clr_ok;
    w_clr     = w_clr_ok ? (FLOORS'(1) << clr_idx) : '0;
    // Clear applied after set: a floor being served stays clear even if
    // its button is pressed in the same cycle.
    w_req_n   = (r_req | w_set) & ~w_clr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req     <= PRESET_VAL;
      r_btn_q   <= btn;
      r_any     <= |PRESET_VAL;
      r_count   <= f_count(PRESET_VAL);
      r_lowest  <= f_lowest(PRESET_VAL);
      r_highest <= f_highest(PRESET_VAL);
      r_new     <= 1'b0;
      r_clr_err <= 1'b0;
    end else begin
      r_req     <= w_req_n;
      r_btn_q   <= btn;
      r_any     <= |w_req_n;
      r_count   <= f_count(w_req_n);
      r_lowest  <= f_lowest(w_req_n);
      r_highest <= f_highest(w_req_n);
      r_new     <= |(w_req_n & ~r_req);
      r_clr_err <= w_clr_bad;
    end
  end

  assign req         = r_req;
  assign any_req     = r_any;
  assign req_count   = r_count;
  assign lowest_idx  = r_lowest;
  assign highest_idx = r_highest;
  assign new_req     = r_new;
  assign clr_err     = r_clr_err;

endmodule

// File: tb/tb_floor_request_bank.sv
// Directed bench for floor_request_bank. Four instances cover edge capture
// (A), level capture (B, sharing A's inputs), a 6-floor bank for the invalid
// clear index (C), and a non-zero reset preset (D).
module tb_floor_request_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // shared by A and B
  logic       rst, en, cv;
  logic [7:0] btn;
  logic [2:0] ci;
  // C
  logic [5:0] btn_c;
  logic       cv_c;
  logic [2:0] ci_c;
  // D
  logic       rst_d, cv_d;
  logic [7:0] btn_d;
  logic [2:0] ci_d;

  logic [7:0] req_a, req_b, req_d;
  logic [5:0] req_c;
  logic       any_a, any_b, any_c, any_d;
  logic [3:0] cnt_a, cnt_b, cnt_d;
  logic [2:0] cnt_c;
  logic [2:0] lo_a, lo_b, lo_c, lo_d, hi_a, hi_b, hi_c, hi_d;
  logic       new_a, new_b, new_c, new_d;
  logic       ce_a, ce_b, ce_c, ce_d;

  floor_request_bank #(.FLOORS(8), .IDX_W(3), .CNT_W(4), .EDGE_MODE(1'b1),
                       .PRESET_VAL(8'h00)) u_a (
    .clk(clk), .reset(rst), .enable(en), .btn(btn), .clr_valid(cv),
    .clr_idx(ci), .req(req_a), .any_req(any_a), .req_count(cnt_a),
    .lowest_idx(lo_a), .highest_idx(hi_a), .new_req(new_a), .clr_err(ce_a));

  floor_request_bank #(.FLOORS(8), .IDX_W(3), .CNT_W(4), .EDGE_MODE(1'b0),
                       .PRESET_VAL(8'h00)) u_b (
    .clk(clk), .reset(rst), .enable(en), .btn(btn), .clr_valid(cv),
    .clr_idx(ci), .req(req_b), .any_req(any_b), .req_count(cnt_b),
    .lowest_idx(lo_b), .highest_idx(hi_b), .new_req(new_b), .clr_err(ce_b));

  floor_request_bank #(.FLOORS(6), .IDX_W(3), .CNT_W(3), .EDGE_MODE(1'b1),
                       .PRESET_VAL(6'h00)) u_c (
    .clk(clk), .reset(rst), .enable(en), .btn(btn_c), .clr_valid(cv_c),
    .clr_idx(ci_c), .req(req_c), .any_req(any_c), .req_count(cnt_c),
    .lowest_idx(lo_c), .highest_idx(hi_c), .new_req(new_c), .clr_err(ce_c));

  floor_request_bank #(.FLOORS(8), .IDX_W(3), .CNT_W(4), .EDGE_MODE(1'b1),
                       .PRESET_VAL(8'h01)) u_d (
    .clk(clk), .reset(rst_d), .enable(en), .btn(btn_d), .clr_valid(cv_d),
    .clr_idx(ci_d), .req(req_d), .any_req(any_d), .req_count(cnt_d),
    .lowest_idx(lo_d), .highest_idx(hi_d), .new_req(new_d), .clr_err(ce_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cv = 1'b0; btn = '0; ci = '0;
    btn_c = '0; cv_c = 1'b0; ci_c = '0;
    rst_d = 1'b1; cv_d = 1'b0; btn_d = '0; ci_d = '0;
    tick();
    check("rst_a_req", 32'(req_a), 32'h00);
    check("rst_a_any", 32'(any_a), 0);
    check("rst_a_cnt", 32'(cnt_a), 0);
    check("rst_a_lo",  32'(lo_a), 0);
    check("rst_a_hi",  32'(hi_a), 0);
    check("rst_a_new", 32'(new_a), 0);
    check("rst_a_ce",  32'(ce_a), 0);
    check("rst_d_req", 32'(req_d), 32'h01);
    check("rst_d_cnt", 32'(cnt_d), 1);
    check("rst_d_any", 32'(any_d), 1);
    check("rst_d_new", 32'(new_d), 0);
    rst = 1'b0; rst_d = 1'b0;

    // one-cycle press of floors 2 and 5
    btn = 8'h24; tick();
    check("t1_req", 32'(req_a), 32'h24);
    check("t1_any", 32'(any_a), 1);
    check("t1_cnt", 32'(cnt_a), 2);
    check("t1_lo",  32'(lo_a), 2);
    check("t1_hi",  32'(hi_a), 5);
    check("t1_new", 32'(new_a), 1);
    btn = 8'h00; tick();
    check("t1_new_drop", 32'(new_a), 0);
    check("t1_req_hold", 32'(req_a), 32'h24);

    // serve floor 5 then floor 2
    cv = 1'b1; ci = 3'd5; tick();
    check("t2_req5", 32'(req_a), 32'h04);
    check("t2_cnt5", 32'(cnt_a), 1);
    check("t2_hi5",  32'(hi_a), 2);
    check("t2_lo5",  32'(lo_a), 2);
    check("t2_new5", 32'(new_a), 0);
    ci = 3'd2; tick();
    check("t2_req2", 32'(req_a), 32'h00);
    check("t2_any2", 32'(any_a), 0);
    check("t2_cnt2", 32'(cnt_a), 0);
    check("t2_lo2",  32'(lo_a), 0);
    check("t2_hi2",  32'(hi_a), 0);
    cv = 1'b0;

    // press and clear same floor: clear wins; held button does not re-latch
    btn = 8'h08; cv = 1'b1; ci = 3'd3; tick();
    check("t3_same_req", 32'(req_a), 32'h00);
    check("t3_same_new", 32'(new_a), 0);
    cv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_held_req", 32'(req_a), 32'h00);
    end
    btn = 8'h00; tick();
    check("t3_release", 32'(req_a), 32'h00);
    btn = 8'h08; tick();
    check("t3_repress_req", 32'(req_a), 32'h08);
    check("t3_repress_new", 32'(new_a), 1);
    check("t3_repress_lo",  32'(lo_a), 3);

    // mid-operation reset discards pending requests (A and B back to 0)
    rst = 1'b1; btn = 8'h00; tick();
    check("t4_rst_a", 32'(req_a), 32'h00);
    check("t4_rst_b", 32'(req_b), 32'h00);
    check("t4_rst_new", 32'(new_a), 0);
    rst = 1'b0;

    // edge while disabled is lost in edge mode; level mode latches on enable
    en = 1'b0; btn = 8'h80; tick();
    check("t4_dis_a", 32'(req_a), 32'h00);
    check("t4_dis_a_new", 32'(new_a), 0);
    check("t4_dis_b", 32'(req_b), 32'h00);
    en = 1'b1; tick();
    check("t4_en_a", 32'(req_a), 32'h00);
    check("t4_en_a_new", 32'(new_a), 0);
    check("t4_en_b", 32'(req_b), 32'h80);
    check("t4_en_b_new", 32'(new_b), 1);
    check("t4_en_b_hi", 32'(hi_b), 7);
    // level mode: cleared while held, re-latches next cycle
    cv = 1'b1; ci = 3'd7; tick();
    check("t4_lvl_clr", 32'(req_b), 32'h00);
    cv = 1'b0; tick();
    check("t4_lvl_relatch", 32'(req_b), 32'h80);
    check("t4_lvl_relatch_new", 32'(new_b), 1);
    // disabled: pending retained, clears still act
    en = 1'b0; btn = 8'h00; tick();
    check("t4_dis_keep", 32'(req_b), 32'h80);
    cv = 1'b1; ci = 3'd7; tick();
    check("t4_dis_clr", 32'(req_b), 32'h00);
    cv = 1'b0; en = 1'b1;

    // 6-floor bank: valid clear then out-of-range clear
    btn_c = 6'h0C; tick();
    check("t5_set", 32'(req_c), 32'h0C);
    check("t5_cnt", 32'(cnt_c), 2);
    btn_c = 6'h00; cv_c = 1'b1; ci_c = 3'd3; tick();
    check("t5_clr3", 32'(req_c), 32'h04);
    check("t5_clr3_err", 32'(ce_c), 0);
    ci_c = 3'd6; tick();
    check("t5_bad_req", 32'(req_c), 32'h04);
    check("t5_bad_err", 32'(ce_c), 1);
    ci_c = 3'd7; tick();
    check("t5_bad7_req", 32'(req_c), 32'h04);
    check("t5_bad7_err", 32'(ce_c), 1);
    cv_c = 1'b0; tick();
    check("t5_err_drop", 32'(ce_c), 0);
    check("t5_req_keep", 32'(req_c), 32'h04);

    // preset reload with buttons held through reset
    btn_d = 8'hFF; tick();
    check("t6_all_req", 32'(req_d), 32'hFF);
    check("t6_all_cnt", 32'(cnt_d), 8);
    check("t6_all_hi",  32'(hi_d), 7);
    check("t6_all_new", 32'(new_d), 1);
    rst_d = 1'b1; tick();
    check("t6_rst_req", 32'(req_d), 32'h01);
    check("t6_rst_cnt", 32'(cnt_d), 1);
    check("t6_rst_new", 32'(new_d), 0);
    rst_d = 1'b0; tick();
    check("t6_post_req", 32'(req_d), 32'h01);
    check("t6_post_new", 32'(new_d), 0);
    tick();
    check("t6_post2_req", 32'(req_d), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
